// File: rtl/cordic_vectoring_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, returns
// magnitude and binary angle of a signed (x,y) vector.
// Optional feature macro: CORDIC_GAIN_COMP_EN (adds a one-cycle COMP state that
// scales the magnitude by ~1/K; undefined by default, magnitude then carries gain K).
module cordic_vectoring_iter #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned ITERATIONS = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] y_in,
  output logic                 busy_output,
  output logic                 valid_output,
  output logic [BIT_WIDTH:0]   mag_output,
  output logic [15:0]          angle_output
);

  localparam int unsigned XW    = BIT_WIDTH + 2;
  localparam int unsigned MAG_W = BIT_WIDTH + 1;
  localparam int unsigned ZW    = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] x_sh, y_sh, x_it, y_it;
  logic [ZW-1:0]        z_q, z_d, z_it, atan_c;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_d, valid_d;
  logic [MAG_W-1:0]     mag_d;
  logic [ZW-1:0]        angle_d;
  logic                 y_neg;

  // Arctangent table in binary-angle units (pi = 32768).
  function automatic logic [ZW-1:0] atan_lut(input logic [CNT_W-1:0] idx);
    case (idx)
      4'd0:    return 16'd8192;
      4'd1:    return 16'd4836;
      4'd2:    return 16'd2555;
      4'd3:    return 16'd1297;
      4'd4:    return 16'd651;
      4'd5:    return 16'd326;
      4'd6:    return 16'd163;
      4'd7:    return 16'd81;
      4'd8:    return 16'd41;
      4'd9:    return 16'd20;
      4'd10:   return 16'd10;
      4'd11:   return 16'd5;
      4'd12:   return 16'd3;
      4'd13:   return 16'd1;
      default: return 16'd0;
    endcase
  endfunction

  // Sign-extended inputs; two extra bits keep negation of the most negative input exact.
  assign x_ext = {{2{x_in[BIT_WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[BIT_WIDTH-1]}}, y_in};

  // One micro-rotation driven toward y=0 by the sign of y.
  assign y_neg  = y_q[XW-1];
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_c = atan_lut(cnt_q);
  assign x_it   = y_neg ? (x_q - y_sh)   : (x_q + y_sh);
  assign y_it   = y_neg ? (y_q + x_sh)   : (y_q - x_sh);
  assign z_it   = y_neg ? (z_q - atan_c) : (z_q + atan_c);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    busy_d  = busy_output;
    valid_d = 1'b0;
    mag_d   = mag_output;
    angle_d = angle_output;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          // Fold left-half-plane vectors into the right half by +/-90 degrees.
          if (!x_in[BIT_WIDTH-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 16'h0000;
          end else if (!y_in[BIT_WIDTH-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = 16'h4000;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = 16'hC000;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        x_d   = x_it;
        y_d   = y_it;
        z_d   = z_it;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = COMP;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          mag_d   = MAG_W'(x_it);
          angle_d = z_it;
`endif
        end
      end

`ifdef CORDIC_GAIN_COMP_EN
      COMP: begin
        // Shift-add approximation of 1/K (~0.6073).
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        mag_d   = MAG_W'((x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6)
                         - (x_q >>> 9) - (x_q >>> 13));
        angle_d = z_q;
      end
`endif

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, accumulators and registered outputs; reset wins over any request.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      cnt_q        <= '0;
      busy_output  <= 1'b0;
      valid_output <= 1'b0;
      mag_output   <= '0;
      angle_output <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      cnt_q        <= cnt_d;
      busy_output  <= busy_d;
      valid_output <= valid_d;
      mag_output   <= mag_d;
      angle_output <= angle_d;
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter: random and directed vectors,
// back-to-back starts, mid-flight starts and mid-run reset.
module tb_cordic_vectoring_iter;

  localparam int BW   = 16;
  localparam int ITER = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif
  localparam int LAT = ITER + (COMP_EN ? 1 : 0);
  localparam real PI = 3.14159265358979;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [BW-1:0] x_in;
  logic [BW-1:0] y_in;
  logic          busy_output;
  logic          valid_output;
  logic [BW:0]   mag_output;
  logic [15:0]   angle_output;

  cordic_vectoring_iter #(.BIT_WIDTH(BW), .ITERATIONS(ITER)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .busy_output  (busy_output),
    .valid_output (valid_output),
    .mag_output   (mag_output),
    .angle_output (angle_output)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int atan_tab [14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};

  typedef struct {
    int e;
    int mag;
    int ang;
  } exp_t;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Bit-exact result of the vectoring algorithm using plain integer arithmetic.
  function automatic void ref_cordic(input int xi, input int yi, output int mag, output int ang);
    longint x, y, z, xs, ys;
    if (xi >= 0) begin
      x = xi;  y = yi;  z = 0;
    end else if (yi >= 0) begin
      x = yi;  y = -xi; z = 16384;
    end else begin
      x = -yi; y = xi;  z = -16384;
    end
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end else begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end
    end
    if (COMP_EN) x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 13);
    mag = int'(x & 64'h1FFFF);
    ang = int'(z & 64'hFFFF);
  endfunction

  // Ideal magnitude including the CORDIC gain (or its compensated value).
  function automatic real ideal_mag(input int xi, input int yi);
    real g = 1.0;
    for (int i = 0; i < ITER; i++) g = g * $sqrt(1.0 + 1.0 / (4.0 ** i));
    if (COMP_EN) g = g * (0.5 + 0.125 - 1.0/64.0 - 1.0/512.0 - 1.0/8192.0);
    return g * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  // Deviation from the ideal value, or 0 when inside the tolerance.
  function automatic int err_or_zero(input int d, input int tol);
    return (d <= tol && d >= -tol) ? 0 : d;
  endfunction

  function automatic int wrap16(input int d);
    return ((d % 65536) + 65536 + 32768) % 65536 - 32768;
  endfunction

  function automatic int rand16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Issue one vector from idle and check latency, pulse width and result.
  task automatic run_vec(input int xv, input int yv, input string tag, input bit ideal);
    int n, em, ea, ia;
    ref_cordic(xv, yv, em, ea);
    @(negedge clk_in);
    x_in = 16'(xv); y_in = 16'(yv); start_in = 1'b1;
    @(posedge clk_in); #1;
    check({tag, "_busy"}, busy_output, 1);
    @(negedge clk_in);
    start_in = 1'b0;
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!valid_output && n < LAT + 10);
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy_done"}, busy_output, 0);
    check({tag, "_mag"}, mag_output, em);
    check({tag, "_angle"}, angle_output, ea);
    if (ideal) begin
      ia = rnd($atan2(real'(yv), real'(xv)) * 32768.0 / PI);
      check({tag, "_angle_err"}, err_or_zero(wrap16(int'(angle_output) - ia), 12), 0);
      check({tag, "_mag_err"}, err_or_zero(int'(mag_output) - rnd(ideal_mag(xv, yv)), 16), 0);
    end
    @(posedge clk_in); #1;
    check({tag, "_pulse"}, valid_output, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int em, ea, nv, xa, ya;
    exp_t q[$];
    bit expv;

    rst_in = 1'b1; start_in = 1'b0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_busy", busy_output, 0);
    check("rst_valid", valid_output, 0);
    check("rst_mag", mag_output, 0);
    check("rst_angle", angle_output, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Directed vectors, including quadrant folds and the negative corner.
    run_vec(1000, 0, "d_1000_0", 1'b1);
    run_vec(1000, 1000, "d_1000_1000", 1'b1);
    run_vec(0, -1000, "d_0_m1000", 1'b1);
    run_vec(-1000, 0, "d_m1000_0", 1'b1);
    run_vec(-1000, -1000, "d_m1000_m1000", 1'b1);
    run_vec(-32768, -32768, "d_corner", 1'b1);
    run_vec(32767, 32767, "d_max", 1'b1);
    run_vec(-32768, 0, "d_negx", 1'b1);
    run_vec(0, 0, "d_zero", 1'b0);
    check("d_zero_mag0", mag_output, 0);

    // Random vectors against the exact and ideal models.
    for (int i = 0; i < 40; i++) run_vec(rand16(), rand16(), "rand", 1'b1);

    // Starts during flight must not disturb the captured vector.
    xa = rand16(); ya = rand16();
    ref_cordic(xa, ya, em, ea);
    @(negedge clk_in);
    x_in = 16'(xa); y_in = 16'(ya); start_in = 1'b1;
    @(posedge clk_in);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      x_in = 16'(rand16()); y_in = 16'(rand16());
    end
    @(negedge clk_in);
    start_in = 1'b0;
    nv = 0;
    while (!valid_output && nv < LAT + 10) begin
      @(posedge clk_in); #1;
      nv++;
    end
    check("ign_valid", valid_output, 1);
    check("ign_mag", mag_output, em);
    check("ign_angle", angle_output, ea);

    // Continuous start requests: accept every LAT+1 cycles, result tracks accepted vector.
    @(posedge clk_in); #1;
    for (int e = 0; e < 40 + LAT + 2; e++) begin
      @(negedge clk_in);
      if (e < 40) begin
        xa = rand16(); ya = rand16();
        x_in = 16'(xa); y_in = 16'(ya); start_in = 1'b1;
        if (e % (LAT + 1) == 0) begin
          ref_cordic(xa, ya, em, ea);
          q.push_back('{e + LAT, em, ea});
        end
      end else begin
        start_in = 1'b0;
      end
      @(posedge clk_in); #1;
      expv = (q.size() > 0) && (q[0].e == e);
      check("b2b_valid", valid_output, expv);
      if (expv) begin
        check("b2b_mag", mag_output, q[0].mag);
        check("b2b_angle", angle_output, q[0].ang);
        void'(q.pop_front());
      end
    end
    check("b2b_drained", q.size(), 0);

    // Reset in the middle of a run clears everything and suppresses the result.
    @(negedge clk_in);
    x_in = 16'(1234); y_in = 16'(-567); start_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    check("mrst_busy", busy_output, 0);
    check("mrst_valid", valid_output, 0);
    check("mrst_mag", mag_output, 0);
    check("mrst_angle", angle_output, 0);
    @(negedge clk_in);
    rst_in = 1'b0; start_in = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      if (valid_output) nv++;
    end
    check("mrst_no_valid", nv, 0);
    run_vec(-700, 2100, "post_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
